// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit FIFOs.
//   UART_BYTE_W       : width of one UART data byte
//   STAT_RX_*         : bit positions of the receive status bits in the CPU status word
//   ptr_inc()         : circular pointer increment for arbitrary (non power-of-two) depths
//   rx_status()       : packs receive status bits into their status-word positions
package uart_pkg;

   localparam int UART_BYTE_W     = 8;

   localparam int STAT_RX_NEMPTY  = 0;
   localparam int STAT_RX_FULL    = 1;
   localparam int STAT_RX_OVERRUN = 2;

   // Explicit compare-and-wrap so depths like 3 or 100 work without masking.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

   function automatic logic [2:0] rx_status(input logic nempty, input logic full,
                                            input logic ovr);
      logic [2:0] s;
      s                  = '0;
      s[STAT_RX_NEMPTY]  = nempty;
      s[STAT_RX_FULL]    = full;
      s[STAT_RX_OVERRUN] = ovr;
      return s;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / CPU side (master) and the receive FIFO (slave).
//   rx_data, rx_valid       : byte strobe from the UART receiver
//   read_req, clear_overrun : CPU pulses
//   data_out, data_valid    : popped byte and its one-cycle qualifier
//   empty, full, count      : fill status
//   overrun, irq            : sticky drop flag and level interrupt
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DEPTH = 128
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [UART_BYTE_W-1:0] rx_data;
   logic                   rx_valid;
   logic                   read_req;
   logic                   clear_overrun;
   logic [UART_BYTE_W-1:0] data_out;
   logic                   data_valid;
   logic                   empty;
   logic                   full;
   logic [CW-1:0]          count;
   logic                   overrun;
   logic                   irq;

   modport master (
      output rx_data, rx_valid, read_req, clear_overrun,
      input  data_out, data_valid, empty, full, count, overrun, irq
   );

   modport slave (
      input  rx_data, rx_valid, read_req, clear_overrun,
      output data_out, data_valid, empty, full, count, overrun, irq
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte array shared by the UART receive and transmit FIFOs.
// Synchronous write, synchronous read with enable; the read register holds
// its value when not enabled and clears on reset. The array is not reset.
// A read and a write to the same address in one cycle return the old byte.
//   clk, rst         : clock, asynchronous active-high reset (read register only)
//   wr_en/addr/data  : write port
//   rd_en/addr/data  : read port, rd_data valid the cycle after rd_en
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [UART_BYTE_W-1:0] wr_data,
   input  logic                   rd_en,
   input  logic [AW-1:0]          rd_addr,
   output logic [UART_BYTE_W-1:0] rd_data
);

   logic [UART_BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and the CPU bus.
// Queues bytes strobed in by the receiver, pops one per read_req with a
// one-cycle registered data_out/data_valid, and reports fill level and a
// sticky overrun flag. A write while full is accepted only if a read pops
// in the same cycle; otherwise the byte is dropped and overrun is set.
// Optional macro UART_RX_FIFO_IRQ_EN: when defined, irq is a registered
// (count >= IRQ_LEVEL) || overrun; when undefined, irq is tied low.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_rx_fifo_if slave modport (all data/status signals)
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH     = 128,
   parameter int IRQ_LEVEL = 1
) (
   input logic           clk,
   input logic           rst,
   uart_rx_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_params
      $error("uart_rx_fifo: DEPTH must be >= 2 and IRQ_LEVEL within 1..DEPTH");
   end

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q, count_nxt;
   logic          overrun_q, overrun_nxt;
   logic          data_valid_q;
   logic          is_empty, is_full;
   logic          wr_acc, rd_acc, drop;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));

   // When full, a same-cycle pop frees the slot being written.
   assign rd_acc = bus.read_req && !is_empty;
   assign wr_acc = bus.rx_valid && (!is_full || bus.read_req);
   assign drop   = bus.rx_valid && is_full && !bus.read_req;

   always_comb begin
      count_nxt = count_q;
      if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);

      // A drop in the same cycle as a clear leaves the flag set.
      overrun_nxt = overrun_q;
      if (drop)                   overrun_nxt = 1'b1;
      else if (bus.clear_overrun) overrun_nxt = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         overrun_q    <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= AW'(ptr_inc(32'(wr_ptr), unsigned'(DEPTH)));
         if (rd_acc) rd_ptr <= AW'(ptr_inc(32'(rd_ptr), unsigned'(DEPTH)));
         count_q      <= count_nxt;
         overrun_q    <= overrun_nxt;
         data_valid_q <= rd_acc;
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (bus.rx_data),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (bus.data_out)
   );

`ifdef UART_RX_FIFO_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= (count_nxt >= CW'(IRQ_LEVEL)) || overrun_nxt;
   end

   assign bus.irq = irq_q;
`else
   assign bus.irq = 1'b0;
`endif

   assign bus.data_valid = data_valid_q;
   assign bus.empty      = is_empty;
   assign bus.full       = is_full;
   assign bus.count      = count_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver and the CPU bus.
- Captures each byte the receiver strobes in, queues it, and serves it to the CPU on a one-cycle read request.
- Reports fill level and a sticky overrun flag for the CPU status register.
- Mirror of the transmit-side FIFO: that one drains to the UART, this one fills from it.

Parameters:
DEPTH, 128, number of byte entries; any integer >= 2, power of two not required.
IRQ_LEVEL, 1, fill level at or above which irq asserts (optional feature only); range 1..DEPTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe: rx_data holds a new byte
read_req  input  1  CPU read pulse: pop head byte
clear_overrun  input  1  pulse: clear overrun flag
data_out  output  8  last popped byte (registered)
data_valid  output  1  one-cycle pulse: data_out updated this cycle
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  $clog2(DEPTH)+1  current number of stored bytes
overrun  output  1  sticky: a received byte was dropped
irq  output  1  level interrupt (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high):
  - write_ptr = 0, read_ptr = 0, count = 0.
  - data_out = 0x00, data_valid = 0, overrun = 0, irq = 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all queued bytes immediately; no partial pop completes.
- Write, accepted when rx_valid && (!full || read_req):
  - Store at write_ptr.
  - write_ptr wraps from DEPTH-1 to 0.
- Write when full and no read_req:
  - Byte dropped; pointers and count unchanged.
  - overrun set next cycle.
- Read, accepted when read_req && !empty:
  - Next edge: data_out = queue[read_ptr], data_valid = 1 for exactly one cycle.
  - read_ptr advances with the same wrap.
  - Latency read_req -> data_valid is 1 cycle.
  - Back-to-back reads on consecutive cycles are allowed and give consecutive bytes.
- Read when empty:
  - Ignored: data_out holds, data_valid = 0, no pointer change.
  - No fall-through: a byte written in the same cycle is not returned.
- Count update:
  - Accepted write only: +1. Accepted read only: -1. Both: unchanged.
  - count never exceeds DEPTH and never underflows.
- Full and simultaneous rx_valid + read_req: both accepted; count stays DEPTH; no overrun.
- overrun:
  - Set by a dropped byte; cleared by clear_overrun.
  - Drop and clear in the same cycle: set wins (flag = 1).
- empty, full, count are registered-state decodes, valid in the cycle after the update.

Optional Feature:
Macro UART_RX_FIFO_IRQ_EN.
- Defined: irq is registered and equals (count >= IRQ_LEVEL) || overrun, evaluated on the post-update state. It deasserts the cycle after the condition clears.
- Not defined: irq is tied to 0, IRQ_LEVEL is unused, and no comparator logic is generated.

Decomposition:
- Shared package uart_pkg:
  - UART_BYTE_W = 8.
  - Status bit positions for CPU status read: STAT_RX_NEMPTY = 0, STAT_RX_FULL = 1, STAT_RX_OVERRUN = 2.
  - Pointer-increment-with-wrap function, shared with the transmit FIFO.
- One natural sub-module: uart_fifo_mem, a simple dual-port byte array (sync write, sync read), DEPTH entries. The same memory serves the transmit FIFO.
- Pointer, count and flag control stay in uart_rx_fifo.

Test Plan:
- Reset then rx_valid with 0x41, 0x42, 0x43 on separate cycles, then three read_req pulses -> data_valid pulses carry 0x41, 0x42, 0x43 in order; count goes 3, 2, 1, 0; empty = 1 at end.
- DEPTH = 4: write 5 bytes 0x10..0x14 with no reads -> full = 1, count = 4, overrun = 1; reads return 0x10..0x13; 0x14 is lost.
- DEPTH = 4, full: rx_valid 0x99 and read_req in the same cycle -> no overrun, count stays 4; after 4 more reads, the last byte returned is 0x99.
- Empty: read_req alone -> no data_valid, data_out unchanged. Empty: rx_valid 0x55 with read_req in the same cycle -> count = 1, no data_valid; next read returns 0x55.
- Wrap-around with DEPTH = 3: 10 interleaved write/read pairs of 0x00..0x09 -> data returned in order; pointers wrap 2 -> 0 with no loss.
- Overrun clear priority, reset mid-operation, and IRQ:
  - Drop and clear_overrun in the same cycle -> overrun = 1.
  - rst asserted with count = 2 -> count = 0 and data_valid = 0 immediately, no clock edge needed.
  - With UART_RX_FIFO_IRQ_EN and IRQ_LEVEL = 2: irq asserts after the 2nd write and drops after the 1st read.
